// File: rtl/regfile_pkg.sv
// Shared defaults and types for the banked register file.
package regfile_pkg;

   localparam int unsigned REGFILE_DATA_W = 32;
   localparam int unsigned REGFILE_ADDR_W = 4;
   localparam int unsigned REGFILE_NREG   = 16;
   localparam int unsigned REGFILE_PC_IDX = 15;

   typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
   typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

   // Write port that wins when both ports target the same register.
   typedef enum logic {
      WPORT_ALU,
      WPORT_LOAD
   } wport_e;

   localparam wport_e WR_PRIORITY = WPORT_ALU;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for outstanding loads.
// A set beats a same-cycle clear; the PC slot can never become pending.
// LOOKAHEAD selects whether BUSY lookups see the next-state (bypass build).
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W    = REGFILE_ADDR_W,
   parameter int unsigned NREG      = REGFILE_NREG,
   parameter int unsigned PC_IDX    = REGFILE_PC_IDX,
   parameter bit          LOOKAHEAD = 1'b0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              set,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [ADDR_W-1:0] a4,
   output logic              busy1,
   output logic              busy2,
   output logic              busy4,
   output logic              any_busy
);

   localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;
   logic [NREG-1:0] pend_src;

   // Next pending state: set has priority over a load-writeback clear.
   always_comb begin
      pend_d = pend_q;
      for (int unsigned r = 0; r < NREG; r++) begin
         if (r == PC_IDX)
            pend_d[IW'(r)] = 1'b0;
         else if (set && (set_addr == ADDR_W'(r)))
            pend_d[IW'(r)] = 1'b1;
         else if (clr && (clr_addr == ADDR_W'(r)))
            pend_d[IW'(r)] = 1'b0;
      end
   end

   // Pending register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn)
         pend_q <= '0;
      else
         pend_q <= pend_d;
   end

   assign pend_src = LOOKAHEAD ? pend_d : pend_q;

   function automatic logic lookup(input logic [ADDR_W-1:0] a,
                                   input logic [NREG-1:0]   v);
      logic b;
      b = 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
         if ((r != PC_IDX) && (a == ADDR_W'(r)))
            b = v[IW'(r)];
      end
      return b;
   endfunction

   assign busy1    = lookup(a1, pend_src);
   assign busy2    = lookup(a2, pend_src);
   assign busy4    = lookup(a4, pend_src);
   assign any_busy = |pend_q;

endmodule

// File: rtl/banked_register_file.sv
// CPU register file: 3 combinational read ports, 2 synchronous write ports,
// PC slot sourced from R15, load scoreboard in regfile_scoreboard.
// Optional macro REGFILE_BYPASS_EN: reads see same-cycle write data and
// BUSY reflects the scoreboard next state. Never applies to the PC slot.
module banked_register_file
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = REGFILE_DATA_W,
   parameter int unsigned ADDR_W = REGFILE_ADDR_W,
   parameter int unsigned NREG   = REGFILE_NREG,
   parameter int unsigned PC_IDX = REGFILE_PC_IDX
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A4,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic [DATA_W-1:0] RD4,
   output logic              BUSY1,
   output logic              BUSY2,
   output logic              BUSY4,
   input  logic [DATA_W-1:0] R15,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WE3,
   input  logic [ADDR_W-1:0] A5,
   input  logic [DATA_W-1:0] WD5,
   input  logic              WE5,
   input  logic              SB_SET,
   input  logic [ADDR_W-1:0] SB_ADDR,
   output logic              ANY_BUSY
);

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   // Next register contents; the higher-priority port is applied last so it wins.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         regs_d[IW'(r)] = regs_q[IW'(r)];
         if (r != PC_IDX) begin
            if (WR_PRIORITY == WPORT_ALU) begin
               if (WE5 && (A5 == ADDR_W'(r))) regs_d[IW'(r)] = WD5;
               if (WE3 && (A3 == ADDR_W'(r))) regs_d[IW'(r)] = WD3;
            end else begin
               if (WE3 && (A3 == ADDR_W'(r))) regs_d[IW'(r)] = WD3;
               if (WE5 && (A5 == ADDR_W'(r))) regs_d[IW'(r)] = WD5;
            end
         end
      end
   end

   // Storage array with synchronous active-low reset overriding writes.
   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         for (int unsigned r = 0; r < NREG; r++)
            regs_q[IW'(r)] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   function automatic logic [DATA_W-1:0] rd_lookup(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      v = '0;
      if (32'(a) == PC_IDX) begin
         v = R15;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            if ((r != PC_IDX) && (a == ADDR_W'(r)))
               v = BYPASS ? regs_d[IW'(r)] : regs_q[IW'(r)];
         end
      end
      return v;
   endfunction

   // Combinational read ports.
   always_comb begin
      RD1 = rd_lookup(A1);
      RD2 = rd_lookup(A2);
      RD4 = rd_lookup(A4);
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NREG     (NREG),
      .PC_IDX   (PC_IDX),
      .LOOKAHEAD(BYPASS)
   ) u_scoreboard (
      .clk     (CLK),
      .resetn  (RESETn),
      .set     (SB_SET),
      .set_addr(SB_ADDR),
      .clr     (WE5),
      .clr_addr(A5),
      .a1      (A1),
      .a2      (A2),
      .a4      (A4),
      .busy1   (BUSY1),
      .busy2   (BUSY2),
      .busy4   (BUSY4),
      .any_busy(ANY_BUSY)
   );

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file (default parameters).
module tb_banked_register_file;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  a1, a2, a4, a3, a5, sb_addr;
   logic [31:0] rd1, rd2, rd4, r15, wd3, wd5;
   logic        busy1, busy2, busy4, we3, we5, sb_set, any_busy;

   int checks = 0;
   int errors = 0;
   bit run    = 1'b0;

   logic [31:0] m_reg  [16];
   logic        m_pend [16];

   banked_register_file #(
      .DATA_W(32),
      .ADDR_W(4),
      .NREG  (16),
      .PC_IDX(15)
   ) dut (
      .CLK     (clk),
      .RESETn  (resetn),
      .A1      (a1),
      .A2      (a2),
      .A4      (a4),
      .RD1     (rd1),
      .RD2     (rd2),
      .RD4     (rd4),
      .BUSY1   (busy1),
      .BUSY2   (busy2),
      .BUSY4   (busy4),
      .R15     (r15),
      .A3      (a3),
      .WD3     (wd3),
      .WE3     (we3),
      .A5      (a5),
      .WD5     (wd5),
      .WE5     (we5),
      .SB_SET  (sb_set),
      .SB_ADDR (sb_addr),
      .ANY_BUSY(any_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural model of one clock edge.
   task automatic model_edge();
      if (!resetn) begin
         for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (we5 && a5 != 4'd15) m_reg[a5] = wd5;
         if (we3 && a3 != 4'd15) m_reg[a3] = wd3;
         if (we5) m_pend[a5] = 1'b0;
         if (sb_set && sb_addr != 4'd15) m_pend[sb_addr] = 1'b1;
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [3:0] a);
      if (a == 4'd15) return r15;
`ifdef REGFILE_BYPASS_EN
      if (we3 && a3 == a) return wd3;
      if (we5 && a5 == a) return wd5;
`endif
      return m_reg[a];
   endfunction

   function automatic logic [31:0] exp_busy(input logic [3:0] a);
      if (a == 4'd15) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (sb_set && sb_addr == a) return 32'd1;
      if (we5 && a5 == a) return 32'd0;
`endif
      return {31'd0, m_pend[a]};
   endfunction

   function automatic logic [31:0] exp_any();
      logic b;
      b = 1'b0;
      for (int i = 0; i < 16; i++) b = b | m_pend[i];
      return {31'd0, b};
   endfunction

   // Per-cycle comparison against the model, half a period after the edge.
   always @(negedge clk) begin
      if (run) begin
         chk("rd1",      rd1,              exp_rd(a1));
         chk("rd2",      rd2,              exp_rd(a2));
         chk("rd4",      rd4,              exp_rd(a4));
         chk("busy1",    {31'd0, busy1},   exp_busy(a1));
         chk("busy2",    {31'd0, busy2},   exp_busy(a2));
         chk("busy4",    {31'd0, busy4},   exp_busy(a4));
         chk("any_busy", {31'd0, any_busy}, exp_any());
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      we3 = 1'b0; we5 = 1'b0; sb_set = 1'b0;
   endtask

   logic [31:0] byp_exp;

   initial begin
      resetn = 1'b0; r15 = 32'h100;
      a1 = '0; a2 = '0; a4 = '0; a3 = '0; a5 = '0; sb_addr = '0;
      wd3 = '0; wd5 = '0;
      idle_inputs();
      tick();
      resetn = 1'b1;
      run = 1'b1;

      // Reset state: all registers zero, nothing pending, PC from R15
      for (int i = 0; i < 15; i++) begin
         tick();
         a1 = 4'(i);
         #2;
         chk("reset_rd", rd1, 32'd0);
         chk("reset_any", {31'd0, any_busy}, 32'd0);
      end
      a1 = 4'd15;
      #2;
      chk("pc_read", rd1, 32'h100);

      // Plain write then read
      tick();
      we3 = 1'b1; a3 = 4'd2; wd3 = 32'hDEADBEEF;
      tick();
      idle_inputs(); a1 = 4'd2;
      #2;
      chk("wr_rd", rd1, 32'hDEADBEEF);

      // Write to PC slot is ignored
      we3 = 1'b1; a3 = 4'd15; wd3 = 32'h1234;
      tick();
      idle_inputs(); a1 = 4'd15;
      #2;
      chk("pc_wr_ignored", rd1, 32'h100);

      // Dual-port conflict: ALU port wins
      we3 = 1'b1; a3 = 4'd4; wd3 = 32'h11;
      we5 = 1'b1; a5 = 4'd4; wd5 = 32'h22;
      tick();
      idle_inputs(); a1 = 4'd4;
      #2;
      chk("dual_wr", rd1, 32'h11);

      // Scoreboard set, then load writeback clears it
      sb_set = 1'b1; sb_addr = 4'd6;
      tick();
      idle_inputs(); a1 = 4'd6;
      #2;
      chk("sb_busy", {31'd0, busy1}, 32'd1);
      chk("sb_any", {31'd0, any_busy}, 32'd1);
      we5 = 1'b1; a5 = 4'd6; wd5 = 32'h55;
      tick();
      idle_inputs();
      #2;
      chk("sb_clr_busy", {31'd0, busy1}, 32'd0);
      chk("sb_clr_rd", rd1, 32'h55);
      chk("sb_clr_any", {31'd0, any_busy}, 32'd0);

      // Set beats same-cycle clear
      sb_set = 1'b1; sb_addr = 4'd6; we5 = 1'b1; a5 = 4'd6; wd5 = 32'h66;
      tick();
      idle_inputs();
      #2;
      chk("sb_set_wins", {31'd0, busy1}, 32'd1);
      chk("sb_set_wins_rd", rd1, 32'h66);
      we5 = 1'b1; a5 = 4'd6; wd5 = 32'h67;
      tick();
      idle_inputs();

      // Same-cycle bypass behaviour on register 7 (currently zero)
      we3 = 1'b1; a3 = 4'd7; wd3 = 32'hA5A5; a2 = 4'd7;
`ifdef REGFILE_BYPASS_EN
      byp_exp = 32'hA5A5;
`else
      byp_exp = 32'h0;
`endif
      #2;
      chk("bypass", rd2, byp_exp);
      tick();
      idle_inputs();
      #2;
      chk("after_wr7", rd2, 32'hA5A5);

      // Reset while a load is pending
      we3 = 1'b1; a3 = 4'd3; wd3 = 32'h77; sb_set = 1'b1; sb_addr = 4'd3;
      tick();
      idle_inputs(); a1 = 4'd3;
      #2;
      chk("midload_busy", {31'd0, busy1}, 32'd1);
      chk("midload_rd", rd1, 32'h77);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #2;
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_rd", rd1, 32'd0);
      chk("rst_any", {31'd0, any_busy}, 32'd0);
      chk("rst_r2", {31'd0, m_reg[2] == 32'd0}, 32'd1);

      // Randomized traffic checked by the per-cycle compare process
      for (int n = 0; n < 3000; n++) begin
         tick();
         resetn  = ($urandom_range(0, 63) != 0);
         a1      = 4'($urandom_range(0, 15));
         a2      = 4'($urandom_range(0, 15));
         a4      = 4'($urandom_range(0, 15));
         a3      = 4'($urandom_range(0, 15));
         a5      = ($urandom_range(0, 3) == 0) ? a3 : 4'($urandom_range(0, 15));
         sb_addr = ($urandom_range(0, 3) == 0) ? a5 : 4'($urandom_range(0, 15));
         wd3     = $urandom;
         wd5     = $urandom;
         r15     = $urandom;
         we3     = ($urandom_range(0, 1) == 1);
         we5     = ($urandom_range(0, 2) == 0);
         sb_set  = ($urandom_range(0, 3) == 0);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      run = 1'b0;
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
